// File: rtl/acc_slv_adapter_pkg.sv
// Default request/response types for the accelerator slave adapter, plus the
// index-width helper used to size counters and pointers.
package acc_slv_adapter_pkg;

    localparam int unsigned AccDataWidth  = 32;
    localparam int unsigned AccExtIdWidth = 2;

    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 1) ? $clog2(num_idx) : 1;
    endfunction

    typedef struct packed {
        logic [AccDataWidth-1:0]  data;
        logic [AccExtIdWidth-1:0] id;
    } acc_ext_q_t;

    typedef struct packed {
        logic [AccDataWidth-1:0]  data;
        logic                     error;
        logic [AccExtIdWidth-1:0] id;
    } acc_ext_p_t;

    typedef struct packed {
        acc_ext_q_t q;
        logic       q_valid;
        logic       p_ready;
    } acc_ext_req_t;

    typedef struct packed {
        logic       q_ready;
        acc_ext_p_t p;
        logic       p_valid;
    } acc_ext_rsp_t;

    typedef struct packed {
        logic [AccDataWidth-1:0] data;
        logic                    id;
    } acc_q_t;

    typedef struct packed {
        logic [AccDataWidth-1:0] data;
        logic                    error;
        logic                    id;
    } acc_p_t;

    typedef struct packed {
        acc_q_t q;
        logic   q_valid;
        logic   p_ready;
    } acc_req_t;

    typedef struct packed {
        logic   q_ready;
        acc_p_t p;
        logic   p_valid;
    } acc_rsp_t;

endpackage

// File: rtl/acc_id_fifo.sv
// In-order store of extended request IDs; pointers wrap modulo Depth so any
// Depth >= 1 works. No bypass: an entry is readable the cycle after its push.
module acc_id_fifo
    import acc_slv_adapter_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 2,
    localparam int unsigned PtrW = idx_width(Depth),
    localparam int unsigned CntW = idx_width(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            i_push,
    input  logic [Width-1:0] i_data,
    input  logic            i_pop,
    output logic [Width-1:0] o_data,
    output logic [CntW-1:0] o_count
);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    // A pop in the same cycle never frees room for a push into a full store.
    assign w_push  = i_push && (r_count != CntW'(Depth));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= next_ptr(r_wptr);
            if (w_pop)  r_rptr <= next_ptr(r_rptr);
            if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/acc_slv_adapter.sv
// Adapts an extended-ID interconnect port to a 1-bit-ID accelerator: request
// IDs are parked in an in-order FIFO and restored onto the matching responses.
module acc_slv_adapter
    import acc_slv_adapter_pkg::*;
#(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned ExtIdWidth = 2,
    parameter int unsigned Depth      = 4,
    parameter type acc_c_ext_req_t = acc_ext_req_t,
    parameter type acc_c_ext_rsp_t = acc_ext_rsp_t,
    parameter type acc_c_req_t     = acc_req_t,
    parameter type acc_c_rsp_t     = acc_rsp_t,
    localparam int unsigned CntW   = idx_width(Depth + 1)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  acc_c_ext_req_t acc_c_slv_req_i,
    output acc_c_ext_rsp_t acc_c_slv_rsp_o,
    output acc_c_req_t     acc_c_mst_req_o,
    input  acc_c_rsp_t     acc_c_mst_rsp_i,
    output logic [CntW-1:0] outstanding_o,
    output logic           idle_o,
    output logic           err_o
);

    logic [CntW-1:0]       w_count;
    logic [ExtIdWidth-1:0] w_head_id;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_spurious;
    logic                  r_err;

    // Full/empty come only from the registered count, keeping q_ready free of
    // any combinational path from the response channel.
    assign w_full     = (w_count == CntW'(Depth));
    assign w_empty    = (w_count == '0);
    assign w_push     = acc_c_slv_req_i.q_valid && acc_c_mst_rsp_i.q_ready && !w_full;
    assign w_pop      = acc_c_mst_rsp_i.p_valid && acc_c_slv_req_i.p_ready && !w_empty;
    assign w_spurious = acc_c_mst_rsp_i.p_valid && w_empty;

    acc_id_fifo #(
        .Depth (Depth),
        .Width (ExtIdWidth)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_data  (acc_c_slv_req_i.q.id),
        .i_pop   (w_pop),
        .o_data  (w_head_id),
        .o_count (w_count)
    );

    always_comb begin
        acc_c_mst_req_o         = '0;
        acc_c_mst_req_o.q.data  = acc_c_slv_req_i.q.data[DataWidth-1:0];
        acc_c_mst_req_o.q.id    = '0;
        acc_c_mst_req_o.q_valid = acc_c_slv_req_i.q_valid && !w_full;
        // With nothing outstanding a response has no owner: accept and drop it.
        acc_c_mst_req_o.p_ready = w_empty ? acc_c_mst_rsp_i.p_valid : acc_c_slv_req_i.p_ready;

        acc_c_slv_rsp_o         = '0;
        acc_c_slv_rsp_o.q_ready = acc_c_mst_rsp_i.q_ready && !w_full;
        acc_c_slv_rsp_o.p.data  = acc_c_mst_rsp_i.p.data[DataWidth-1:0];
        acc_c_slv_rsp_o.p.error = acc_c_mst_rsp_i.p.error;
        acc_c_slv_rsp_o.p.id    = w_head_id;
        acc_c_slv_rsp_o.p_valid = acc_c_mst_rsp_i.p_valid && !w_empty;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)         r_err <= 1'b0;
        else if (w_spurious) r_err <= 1'b1;
    end

    assign outstanding_o = w_count;
    assign idle_o        = w_empty;
    assign err_o         = r_err;

endmodule

// File: tb/tb_acc_slv_adapter.sv
// Scoreboard bench for acc_slv_adapter with Depth=4, ExtIdWidth=3.
module tb_acc_slv_adapter;

    typedef struct packed { logic [31:0] data; logic [2:0] id; } ext_q_t;
    typedef struct packed { logic [31:0] data; logic error; logic [2:0] id; } ext_p_t;
    typedef struct packed { ext_q_t q; logic q_valid; logic p_ready; } ext_req_t;
    typedef struct packed { logic q_ready; ext_p_t p; logic p_valid; } ext_rsp_t;
    typedef struct packed { logic [31:0] data; logic id; } a_q_t;
    typedef struct packed { logic [31:0] data; logic error; logic id; } a_p_t;
    typedef struct packed { a_q_t q; logic q_valid; logic p_ready; } a_req_t;
    typedef struct packed { logic q_ready; a_p_t p; logic p_valid; } a_rsp_t;

    logic     clk;
    logic     rst_n;
    ext_req_t slv_req;
    ext_rsp_t slv_rsp;
    a_req_t   mst_req;
    a_rsp_t   mst_rsp;
    logic [2:0] outstanding;
    logic     idle;
    logic     err;

    int       n_tests;
    int       n_fail;
    int       n_pop;
    int       m_cnt;
    logic     m_err;
    logic [2:0] m_q[$];

    acc_slv_adapter #(
        .DataWidth       (32),
        .ExtIdWidth      (3),
        .Depth           (4),
        .acc_c_ext_req_t (ext_req_t),
        .acc_c_ext_rsp_t (ext_rsp_t),
        .acc_c_req_t     (a_req_t),
        .acc_c_rsp_t     (a_rsp_t)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .acc_c_slv_req_i (slv_req),
        .acc_c_slv_rsp_o (slv_rsp),
        .acc_c_mst_req_o (mst_req),
        .acc_c_mst_rsp_i (mst_rsp),
        .outstanding_o   (outstanding),
        .idle_o          (idle),
        .err_o           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and update the reference model from the inputs seen at the edge.
    task automatic tick();
        logic q_hs, p_hs, spur;
        @(posedge clk);
        if (!rst_n) begin
            m_cnt = 0;
            m_q.delete();
            m_err = 1'b0;
        end else begin
            q_hs = slv_req.q_valid && mst_rsp.q_ready && (m_cnt < 4);
            p_hs = mst_rsp.p_valid && slv_req.p_ready && (m_cnt > 0);
            spur = mst_rsp.p_valid && (m_cnt == 0);
            if (p_hs) begin
                void'(m_q.pop_front());
                m_cnt--;
                n_pop++;
            end
            if (q_hs) begin
                m_q.push_back(slv_req.q.id);
                m_cnt++;
            end
            if (spur) m_err = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mst_rsp.q_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_tests++; if (slv_rsp.q_ready !== 1'b1) begin n_fail++; $display("FAIL reset_q_ready: got %b want 1", slv_rsp.q_ready); end
        n_tests++; if (slv_rsp.p_valid !== 1'b0) begin n_fail++; $display("FAIL reset_p_valid: got %b want 0", slv_rsp.p_valid); end
    endtask

    task automatic test_single();
        slv_req.q.id    = 3'b101;
        slv_req.q.data  = 32'hA5A5_0001;
        slv_req.q_valid = 1'b1;
        slv_req.p_ready = 1'b1;
        mst_rsp.q_ready = 1'b1;
        #1;
        n_tests++; if (mst_req.q_valid !== 1'b1) begin n_fail++; $display("FAIL single_mst_qv: got %b want 1", mst_req.q_valid); end
        n_tests++; if (mst_req.q.id !== 1'b0) begin n_fail++; $display("FAIL single_mst_qid: got %b want 0", mst_req.q.id); end
        n_tests++; if (mst_req.q.data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_mst_qdata: got %h want a5a50001", mst_req.q.data); end
        tick();
        slv_req.q_valid = 1'b0;
        #1;
        n_tests++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL single_out1: got %0d want 1", outstanding); end
        n_tests++; if (idle !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", idle); end
        tick();
        mst_rsp.p_valid = 1'b1;
        mst_rsp.p.id    = 1'b0;
        mst_rsp.p.data  = 32'h0000_1234;
        mst_rsp.p.error = 1'b0;
        #1;
        n_tests++; if (slv_rsp.p_valid !== 1'b1) begin n_fail++; $display("FAIL single_pv: got %b want 1", slv_rsp.p_valid); end
        n_tests++; if (slv_rsp.p.id !== 3'b101) begin n_fail++; $display("FAIL single_pid: got %b want 101", slv_rsp.p.id); end
        n_tests++; if (slv_rsp.p.data !== 32'h0000_1234) begin n_fail++; $display("FAIL single_pdata: got %h want 00001234", slv_rsp.p.data); end
        tick();
        mst_rsp.p_valid = 1'b0;
        #1;
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL single_out0: got %0d want 0", outstanding); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle: got %b want 1", idle); end
    endtask

    task automatic test_back_to_back();
        int  nid;
        int  k;
        logic exp_rdy;
        nid = 1;
        k = 0;
        mst_rsp.q_ready = 1'b1;
        mst_rsp.p_valid = 1'b0;
        slv_req.p_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            slv_req.q_valid = 1'b1;
            slv_req.q.id    = 3'(nid);
            slv_req.q.data  = 32'(nid);
            #1;
            exp_rdy = (m_cnt < 4);
            n_tests++; if (slv_rsp.q_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_qready[%0d]: got %b want %b", c, slv_rsp.q_ready, exp_rdy); end
            tick();
            if (exp_rdy) nid++;
        end
        n_tests++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL b2b_full_cnt: got %0d want 4", outstanding); end
        n_tests++; if (slv_rsp.q_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_qready: got %b want 0", slv_rsp.q_ready); end
        // Full store with a response and id 5 both offered: push must wait a cycle.
        mst_rsp.p_valid = 1'b1;
        mst_rsp.p.id    = 1'b0;
        #1;
        n_tests++; if (slv_rsp.q_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_pop_push_qready: got %b want 0", slv_rsp.q_ready); end
        n_tests++; if (slv_rsp.p.id !== 3'(k + 1)) begin n_fail++; $display("FAIL b2b_order[%0d]: got %0d want %0d", k, slv_rsp.p.id, k + 1); end
        k++;
        tick();
        #1;
        n_tests++; if (slv_rsp.q_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_retry_qready: got %b want 1", slv_rsp.q_ready); end
        n_tests++; if (slv_rsp.p.id !== 3'(k + 1)) begin n_fail++; $display("FAIL b2b_order[%0d]: got %0d want %0d", k, slv_rsp.p.id, k + 1); end
        k++;
        tick();
        slv_req.q_valid = 1'b0;
        for (int c = 0; c < 10 && m_cnt > 0; c++) begin
            #1;
            n_tests++; if (slv_rsp.p.id !== 3'(k + 1)) begin n_fail++; $display("FAIL b2b_order[%0d]: got %0d want %0d", k, slv_rsp.p.id, k + 1); end
            k++;
            tick();
        end
        mst_rsp.p_valid = 1'b0;
        #1;
        n_tests++; if (k !== 5) begin n_fail++; $display("FAIL b2b_resp_count: got %0d want 5", k); end
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL b2b_drained: got %0d want 0", outstanding); end
    endtask

    task automatic test_spurious();
        mst_rsp.p_valid = 1'b1;
        slv_req.p_ready = 1'b0;
        #1;
        n_tests++; if (mst_req.p_ready !== 1'b1) begin n_fail++; $display("FAIL spur_p_ready: got %b want 1", mst_req.p_ready); end
        n_tests++; if (slv_rsp.p_valid !== 1'b0) begin n_fail++; $display("FAIL spur_p_valid: got %b want 0", slv_rsp.p_valid); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL spur_err_early: got %b want 0", err); end
        tick();
        mst_rsp.p_valid = 1'b0;
        #1;
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL spur_err_set: got %b want 1", err); end
        tick();
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL spur_err_sticky: got %b want 1", err); end
        n_tests++; if (slv_rsp.q_ready !== 1'b1) begin n_fail++; $display("FAIL spur_not_blocking: got %b want 1", slv_rsp.q_ready); end
    endtask

    task automatic test_reset_mid();
        mst_rsp.q_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            slv_req.q_valid = 1'b1;
            slv_req.q.id    = 3'(6 + c);
            tick();
        end
        slv_req.q_valid = 1'b0;
        #1;
        n_tests++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL rmid_out3: got %0d want 3", outstanding); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL rmid_out0: got %0d want 0", outstanding); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rmid_idle: got %b want 1", idle); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rmid_err_clr: got %b want 0", err); end
        mst_rsp.p_valid = 1'b1;
        slv_req.p_ready = 1'b1;
        #1;
        n_tests++; if (slv_rsp.p_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale_pv: got %b want 0", slv_rsp.p_valid); end
        n_tests++; if (mst_req.p_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_stale_pr: got %b want 1", mst_req.p_ready); end
        tick();
        mst_rsp.p_valid = 1'b0;
        #1;
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL rmid_stale_err: got %b want 1", err); end
    endtask

    task automatic test_random();
        int   issued;
        logic exp_qr, exp_pv, acc;
        issued = 0;
        n_pop  = 0;
        for (int cyc = 0; cyc < 20000 && n_pop < 1000; cyc++) begin
            slv_req.q_valid = (issued < 1000) && 1'($urandom_range(0, 1));
            slv_req.q.id    = 3'(issued);
            slv_req.q.data  = $urandom;
            mst_rsp.q_ready = ($urandom_range(0, 3) != 0);
            mst_rsp.p_valid = (m_cnt > 0) && 1'($urandom_range(0, 1));
            mst_rsp.p.id    = 1'b0;
            mst_rsp.p.data  = $urandom;
            mst_rsp.p.error = 1'($urandom_range(0, 1));
            slv_req.p_ready = 1'($urandom_range(0, 1));
            #1;
            exp_qr = mst_rsp.q_ready && (m_cnt < 4);
            exp_pv = mst_rsp.p_valid && (m_cnt > 0);
            n_tests++; if (outstanding !== 3'(m_cnt)) begin n_fail++; $display("FAIL rnd_outstanding@%0d: got %0d want %0d", cyc, outstanding, m_cnt); end
            n_tests++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err@%0d: got %b want %b", cyc, err, m_err); end
            n_tests++; if (slv_rsp.q_ready !== exp_qr) begin n_fail++; $display("FAIL rnd_qready@%0d: got %b want %b", cyc, slv_rsp.q_ready, exp_qr); end
            n_tests++; if (slv_rsp.p_valid !== exp_pv) begin n_fail++; $display("FAIL rnd_pvalid@%0d: got %b want %b", cyc, slv_rsp.p_valid, exp_pv); end
            if (exp_pv && slv_req.p_ready) begin
                n_tests++; if (slv_rsp.p.id !== m_q[0]) begin n_fail++; $display("FAIL rnd_pid@%0d: got %0d want %0d", cyc, slv_rsp.p.id, m_q[0]); end
                n_tests++; if (slv_rsp.p.data !== mst_rsp.p.data) begin n_fail++; $display("FAIL rnd_pdata@%0d: got %h want %h", cyc, slv_rsp.p.data, mst_rsp.p.data); end
            end
            acc = slv_req.q_valid && exp_qr;
            tick();
            if (acc) issued++;
        end
        slv_req.q_valid = 1'b0;
        mst_rsp.p_valid = 1'b0;
        n_tests++; if (n_pop !== 1000) begin n_fail++; $display("FAIL rnd_completed: got %0d want 1000", n_pop); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        n_pop   = 0;
        m_cnt   = 0;
        m_err   = 1'b0;
        rst_n   = 1'b0;
        slv_req = '0;
        mst_rsp = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
